// File: rtl/memory_dp_if.sv
// Dual-port memory bus: one fetch port (i_*) and one load/store port (d_*).
// Ports: i_req/i_address -> i_read_data/i_valid; d_req/d_wEn/d_size/d_unsigned/
//        d_address/d_write_data -> d_read_data/d_valid/d_error.
// Latency: one cycle for both ports. Backpressure: none; one request per port per cycle.
interface memory_dp_if #(
  parameter int ADDR_WIDTH = 16
);
  // Fetch port
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [31:0]           i_read_data;
  logic                  i_valid;

  // Data port
  logic                  d_req;
  logic                  d_wEn;
  logic [1:0]            d_size;
  logic                  d_unsigned;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [31:0]           d_write_data;
  logic [31:0]           d_read_data;
  logic                  d_valid;
  logic                  d_error;

  // Requester side
  modport master (
    output i_req, i_address,
    input  i_read_data, i_valid,
    output d_req, d_wEn, d_size, d_unsigned, d_address, d_write_data,
    input  d_read_data, d_valid, d_error
  );

  // Memory side
  modport slave (
    input  i_req, i_address,
    output i_read_data, i_valid,
    input  d_req, d_wEn, d_size, d_unsigned, d_address, d_write_data,
    output d_read_data, d_valid, d_error
  );
endinterface

// File: rtl/memory_dp.sv
// Dual-port 32-bit memory: word fetch port plus byte/half/word load/store port.
// Ports: clock, reset (async active-high), bus (memory_dp_if.slave).
// Latency: responses registered, valid one cycle after the request edge, held one cycle.
// Backpressure: none; both ports accept a request every cycle.
// Option: define MEMORY_DP_FWD_EN to make a fetch that collides with a same-cycle
//         store to the same word return the merged post-store word (default: pre-store).
module memory_dp #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic        clock,
  input  logic        reset,
  memory_dp_if.slave  bus
);

  localparam int          IDX_W   = ADDR_WIDTH - 2;
  localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  // Storage is deliberately not reset.
  logic [31:0] mem_q [DEPTH];

  // Address decode
  logic [IDX_W-1:0]  i_widx;
  logic [IDX_W-1:0]  d_widx;
  logic [MEM_AW-1:0] i_maddr;
  logic [MEM_AW-1:0] d_maddr;
  logic [1:0]        d_lane;
  logic              i_in_range;
  logic              d_in_range;
  logic              unused_i_lane;

  assign i_widx        = bus.i_address[ADDR_WIDTH-1:2];
  assign d_widx        = bus.d_address[ADDR_WIDTH-1:2];
  assign i_maddr       = i_widx[MEM_AW-1:0];
  assign d_maddr       = d_widx[MEM_AW-1:0];
  assign d_lane        = bus.d_address[1:0];
  assign i_in_range    = 32'(i_widx) < DEPTH_U;
  assign d_in_range    = 32'(d_widx) < DEPTH_U;
  // Fetches are always whole words; the lane bits carry no meaning.
  assign unused_i_lane = ^bus.i_address[1:0];

  // Data-port request checking
  logic d_err;
  always_comb begin
    d_err = !d_in_range;
    case (bus.d_size)
      2'b00:   d_err = !d_in_range;
      2'b01:   if (d_lane[0]) d_err = 1'b1;
      2'b10:   if (d_lane != 2'b00) d_err = 1'b1;
      default: d_err = 1'b1;
    endcase
  end

  // Store lane enables; data replicated so each lane sees the right bytes.
  logic [3:0]  wr_be;
  logic [31:0] wr_dat;
  logic        wr_en;
  always_comb begin
    wr_be  = 4'b0000;
    wr_dat = bus.d_write_data;
    case (bus.d_size)
      2'b00: begin
        wr_be  = 4'b0001 << d_lane;
        wr_dat = {4{bus.d_write_data[7:0]}};
      end
      2'b01: begin
        wr_be  = d_lane[1] ? 4'b1100 : 4'b0011;
        wr_dat = {2{bus.d_write_data[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // A store sampled while reset is high must not land in the array.
  assign wr_en = bus.d_req & bus.d_wEn & ~d_err & ~reset;

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) begin
        mem_q[d_maddr][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  // Load alignment and extension
  logic [31:0] d_word;
  logic [31:0] d_shift;
  logic [31:0] load_val;
  always_comb begin
    d_word  = mem_q[d_maddr];
    d_shift = d_word >> {d_lane, 3'b000};
    case (bus.d_size)
      2'b00:   load_val = {{24{~bus.d_unsigned & d_shift[7]}},  d_shift[7:0]};
      2'b01:   load_val = {{16{~bus.d_unsigned & d_shift[15]}}, d_shift[15:0]};
      default: load_val = d_word;
    endcase
  end

  // Fetch word, optionally merged with a colliding store
  logic [31:0] fetch_word;
  always_comb begin
    fetch_word = mem_q[i_maddr];
`ifdef MEMORY_DP_FWD_EN
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b] && (i_widx == d_widx)) begin
        fetch_word[8*b +: 8] = wr_dat[8*b +: 8];
      end
    end
`endif
  end

  // Response next-state
  logic        i_valid_d, i_valid_q;
  logic [31:0] i_rdata_d, i_rdata_q;
  logic        d_valid_d, d_valid_q;
  logic        d_error_d, d_error_q;
  logic [31:0] d_rdata_d, d_rdata_q;

  always_comb begin
    i_valid_d = bus.i_req;
    i_rdata_d = (bus.i_req && i_in_range) ? fetch_word : 32'd0;
    d_valid_d = bus.d_req;
    d_error_d = bus.d_req & d_err;
    // Stores and rejected requests answer with zero data.
    d_rdata_d = (bus.d_req && !d_err && !bus.d_wEn) ? load_val : 32'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_valid_q <= 1'b0;
      i_rdata_q <= 32'd0;
      d_valid_q <= 1'b0;
      d_error_q <= 1'b0;
      d_rdata_q <= 32'd0;
    end else begin
      i_valid_q <= i_valid_d;
      i_rdata_q <= i_rdata_d;
      d_valid_q <= d_valid_d;
      d_error_q <= d_error_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.i_valid     = i_valid_q;
  assign bus.i_read_data = i_rdata_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.d_error     = d_error_q;
  assign bus.d_read_data = d_rdata_q;

endmodule

// File: doc/memory_dp.md
MEMORY_DP -- requirements
Module: memory_dp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width of both ports.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit storage words; DATA width is fixed at 32.
REQ-003 SHALL have ports: clock  in  1  rising-edge clock; reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: i_req  in  1  fetch request; i_address  in  ADDR_WIDTH  fetch byte address.
REQ-005 SHALL have ports: i_read_data  out  32  fetched word; i_valid  out  1  fetch response strobe.
REQ-006 SHALL have ports: d_req  in  1  data request; d_wEn  in  1  1=store, 0=load; d_size  in  2  00 byte, 01 half, 10 word.
REQ-007 SHALL have ports: d_unsigned  in  1  load zero-extend; d_address  in  ADDR_WIDTH  data byte address; d_write_data  in  32  store data.
REQ-008 SHALL have ports: d_read_data  out  32  load result; d_valid  out  1  data response strobe; d_error  out  1  request rejected.

Function
REQ-009 SHALL index storage by word = address[ADDR_WIDTH-1:2]; byte lane = address[1:0], little-endian.
REQ-010 SHALL register all responses: a request accepted at edge N produces valid/data after edge N, held exactly one cycle.
REQ-011 SHALL accept a new request on each port every cycle (no backpressure, no ready signal).
REQ-012 SHALL on i_req return the full word at the indexed address; i_address[1:0] SHALL be ignored.
REQ-013 SHALL on load return selected lane(s) right-justified, sign-extended unless d_unsigned=1; word loads ignore d_unsigned.
REQ-014 SHALL on store update only the addressed lanes: byte writes d_write_data[7:0], half writes d_write_data[15:0]; other lanes unchanged.
REQ-015 SHALL respond to a store with d_valid=1, d_read_data=0, d_error=0.
REQ-016 SHALL flag error (d_valid=1, d_error=1, d_read_data=0, no write) for: half with address[0]=1; word with address[1:0]!=0; d_size=11; word index >= DEPTH.
REQ-017 SHALL for fetch with word index >= DEPTH return i_valid=1, i_read_data=0.
REQ-018 SHALL hold i_read_data/d_read_data/d_error at 0 while the matching valid is 0.
REQ-019 SHALL, when d_req=0, ignore d_wEn (no write ever occurs without d_req).
REQ-020 SHALL give a load to the word being stored in the same cycle on the d port impossible (one op per port per cycle); consecutive store then load to same address SHALL return the stored data.

Reset
REQ-021 SHALL on reset asynchronously clear i_valid, d_valid, d_error, i_read_data, d_read_data to 0.
REQ-022 SHALL NOT clear storage contents on reset; contents are undefined until written.
REQ-023 SHALL discard any request accepted at the edge coincident with reset assertion; stores at that edge SHALL NOT commit.

Configuration
REQ-024 SHALL support macro MEMORY_DP_FWD_EN controlling same-cycle fetch/store collision to one word.
REQ-025 SHALL with MEMORY_DP_FWD_EN defined return to i_read_data the post-store merged word (write-first).
REQ-026 SHALL without MEMORY_DP_FWD_EN return to i_read_data the pre-store word (read-first).

Verification
REQ-027 SHALL verify: reset, store word 0xDEADBEEF at 0x0010, load word 0x0010 -> d_valid one cycle later, d_read_data=0xDEADBEEF.
REQ-028 SHALL verify: store byte 0x80 at 0x0013, load byte signed 0x0013 -> 0xFFFFFF80; unsigned -> 0x00000080; fetch 0x0010 -> 0x80ADBEEF.
REQ-029 SHALL verify: load half at 0x0011 -> d_error=1, d_read_data=0; store word at 0x0012 -> d_error=1, memory word unchanged.
REQ-030 SHALL verify: d_address=DEPTH*4 load -> d_error=1; fetch same address -> i_valid=1, i_read_data=0.
REQ-031 SHALL verify: word at 0x0020=0x11111111, same-cycle store 0x22222222 and fetch 0x0020 -> 0x22222222 with FWD_EN, 0x11111111 without.
REQ-032 SHALL verify: assert reset while d_valid=1 -> all outputs 0 immediately without clock edge; previously stored data still readable after release.
